// File: rtl/baccarat_pkg.sv
// Shared types and helpers for the baccarat round controller.
// The CLEAR state exists only when NEW_ROUND_EN is defined.
package baccarat_pkg;

    localparam int unsigned SCORE_W = 4;
    localparam int unsigned CARD_W  = 4;
    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        DEAL_P1 = 4'd0,
        DEAL_D1 = 4'd1,
        DEAL_P2 = 4'd2,
        DEAL_D2 = 4'd3,
        EVAL4   = 4'd4,
        DEAL_P3 = 4'd5,
        EVAL_D3 = 4'd6,
        DEAL_D3 = 4'd7,
        DONE    = 4'd8
`ifdef NEW_ROUND_EN
        ,
        CLEAR   = 4'd9
`endif
    } state_t;

    // Rank 1..13 to point value; tens and face cards count zero.
    function automatic logic [SCORE_W-1:0] card_value(input logic [CARD_W-1:0] rank);
        return (rank >= CARD_W'(10)) ? '0 : SCORE_W'(rank);
    endfunction

endpackage

// File: rtl/third_card_rule.sv
// Dealer third-card decision from dealer score and player third-card value.
module third_card_rule
    import baccarat_pkg::*;
(
    input  logic [SCORE_W-1:0] dscore,
    input  logic [SCORE_W-1:0] v,
    output logic               dealer_draws
);

    always_comb begin
        dealer_draws = 1'b0;
        case (dscore)
            SCORE_W'(0), SCORE_W'(1), SCORE_W'(2):
                dealer_draws = 1'b1;
            SCORE_W'(3):
                dealer_draws = (v != SCORE_W'(8));
            SCORE_W'(4):
                dealer_draws = (v >= SCORE_W'(2)) && (v <= SCORE_W'(7));
            SCORE_W'(5):
                dealer_draws = (v >= SCORE_W'(4)) && (v <= SCORE_W'(7));
            SCORE_W'(6):
                dealer_draws = (v >= SCORE_W'(6)) && (v <= SCORE_W'(7));
            default:
                dealer_draws = 1'b0;
        endcase
    end

endmodule

// File: rtl/deal_sequencer.sv
// Baccarat round controller: deal strobes, third-card decisions, win lights.
// Optional NEW_ROUND_EN adds new_round / clear_hand / rounds_played and a CLEAR state.
module deal_sequencer
    import baccarat_pkg::*;
`ifdef NEW_ROUND_EN
#(
    parameter int unsigned CNT_W = 8
)
`endif
(
    input  logic               slow_clock,
    input  logic               resetb,
    input  logic [CARD_W-1:0]  pcard3,
    input  logic [SCORE_W-1:0] pscore,
    input  logic [SCORE_W-1:0] dscore,
`ifdef NEW_ROUND_EN
    input  logic               new_round,
    output logic               clear_hand,
    output logic [CNT_W-1:0]   rounds_played,
`endif
    output logic               load_pcard1,
    output logic               load_pcard2,
    output logic               load_pcard3,
    output logic               load_dcard1,
    output logic               load_dcard2,
    output logic               load_dcard3,
    output logic               player_win_light,
    output logic               dealer_win_light
);

    state_t             state_q;
    state_t             state_d;
    logic [SCORE_W-1:0] p3_value;
    logic               dealer_draws;

    assign p3_value = card_value(pcard3);

    third_card_rule u_third_card_rule (
        .dscore       (dscore),
        .v            (p3_value),
        .dealer_draws (dealer_draws)
    );

    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            state_q <= DEAL_P1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            DEAL_P1: state_d = DEAL_D1;
            DEAL_D1: state_d = DEAL_P2;
            DEAL_P2: state_d = DEAL_D2;
            DEAL_D2: state_d = EVAL4;
            EVAL4: begin
                if ((pscore >= SCORE_W'(8)) || (dscore >= SCORE_W'(8))) begin
                    state_d = DONE;
                end else if (pscore <= SCORE_W'(5)) begin
                    state_d = DEAL_P3;
                end else if (dscore <= SCORE_W'(5)) begin
                    state_d = DEAL_D3;
                end else begin
                    state_d = DONE;
                end
            end
            DEAL_P3: state_d = EVAL_D3;
            EVAL_D3: state_d = dealer_draws ? DEAL_D3 : DONE;
            DEAL_D3: state_d = DONE;
`ifdef NEW_ROUND_EN
            DONE:    state_d = new_round ? CLEAR : DONE;
            CLEAR:   state_d = DEAL_P1;
`else
            DONE:    state_d = DONE;
`endif
            default: state_d = DEAL_P1;
        endcase
    end

    // Moore outputs; the first strobe is held off while reset is asserted
    always_comb begin
        load_pcard1      = 1'b0;
        load_pcard2      = 1'b0;
        load_pcard3      = 1'b0;
        load_dcard1      = 1'b0;
        load_dcard2      = 1'b0;
        load_dcard3      = 1'b0;
        player_win_light = 1'b0;
        dealer_win_light = 1'b0;
`ifdef NEW_ROUND_EN
        clear_hand       = 1'b0;
`endif
        case (state_q)
            DEAL_P1: load_pcard1 = resetb;
            DEAL_D1: load_dcard1 = 1'b1;
            DEAL_P2: load_pcard2 = 1'b1;
            DEAL_D2: load_dcard2 = 1'b1;
            DEAL_P3: load_pcard3 = 1'b1;
            DEAL_D3: load_dcard3 = 1'b1;
            DONE: begin
                player_win_light = (pscore >= dscore);
                dealer_win_light = (dscore >= pscore);
            end
`ifdef NEW_ROUND_EN
            CLEAR:   clear_hand = 1'b1;
`endif
            default: ;
        endcase
    end

`ifdef NEW_ROUND_EN
    always_ff @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            rounds_played <= '0;
        end else if ((state_q == DONE) && new_round) begin
            rounds_played <= rounds_played + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_deal_sequencer.sv
// Self-checking bench for deal_sequencer with a card-datapath stand-in and a round-level model.
module tb_deal_sequencer;
    import baccarat_pkg::*;

    logic       slow_clock = 1'b0;
    logic       resetb     = 1'b0;
    logic [3:0] pcard3;
    logic [3:0] pscore;
    logic [3:0] dscore;
    logic       load_pcard1, load_pcard2, load_pcard3;
    logic       load_dcard1, load_dcard2, load_dcard3;
    logic       player_win_light, dealer_win_light;
`ifdef NEW_ROUND_EN
    logic       new_round = 1'b0;
    logic       clear_hand;
    logic [7:0] rounds_played;
`endif

    // Deal order: [0]=p1 [1]=d1 [2]=p2 [3]=d2 [4]=p3 [5]=d3
    logic [5:0][3:0] cards = '0;
    int tests = 0;
    int fails = 0;

    always #5 slow_clock = ~slow_clock;

    deal_sequencer dut (
        .slow_clock       (slow_clock),
        .resetb           (resetb),
        .pcard3           (pcard3),
        .pscore           (pscore),
        .dscore           (dscore),
`ifdef NEW_ROUND_EN
        .new_round        (new_round),
        .clear_hand       (clear_hand),
        .rounds_played    (rounds_played),
`endif
        .load_pcard1      (load_pcard1),
        .load_pcard2      (load_pcard2),
        .load_pcard3      (load_pcard3),
        .load_dcard1      (load_dcard1),
        .load_dcard2      (load_dcard2),
        .load_dcard3      (load_dcard3),
        .player_win_light (player_win_light),
        .dealer_win_light (dealer_win_light)
    );

    function automatic int unsigned cv(input logic [3:0] r);
        return (r > 4'd9) ? 0 : int'(r);
    endfunction

    function automatic logic [3:0] add_card(input logic [3:0] s, input logic [3:0] r);
        return 4'((int'(s) + cv(r)) % 10);
    endfunction

    // Card datapath stand-in: captures each card on the edge that ends its strobe
    always @(posedge slow_clock or negedge resetb) begin
        if (!resetb) begin
            pscore <= '0;
            dscore <= '0;
            pcard3 <= '0;
`ifdef NEW_ROUND_EN
        end else if (clear_hand) begin
            pscore <= '0;
            dscore <= '0;
            pcard3 <= '0;
`endif
        end else begin
            if (load_pcard1) pscore <= add_card(pscore, cards[0]);
            if (load_dcard1) dscore <= add_card(dscore, cards[1]);
            if (load_pcard2) pscore <= add_card(pscore, cards[2]);
            if (load_dcard2) dscore <= add_card(dscore, cards[3]);
            if (load_pcard3) begin
                pscore <= add_card(pscore, cards[4]);
                pcard3 <= cards[4];
            end
            if (load_dcard3) dscore <= add_card(dscore, cards[5]);
        end
    end

    function automatic logic [5:0] loads();
        return {load_dcard3, load_pcard3, load_dcard2, load_pcard2, load_dcard1, load_pcard1};
    endfunction

    // Highest dealer total that still draws, given the player's third-card value
    function automatic int unsigned dealer_limit(input int unsigned v);
        case (v)
            2, 3:    return 4;
            4, 5:    return 5;
            6, 7:    return 6;
            8:       return 2;
            default: return 3;
        endcase
    endfunction

    // Round-level reference: strobe order code, cycles to DONE, final lights
    function automatic void ref_round(input logic [5:0][3:0] c, output int unsigned seq,
                                      output int unsigned cyc, output logic pw, output logic dw);
        int unsigned p, d, v3;
        bit pd, dd;
        p  = (cv(c[0]) + cv(c[2])) % 10;
        d  = (cv(c[1]) + cv(c[3])) % 10;
        pd = 0;
        dd = 0;
        if (p < 8 && d < 8) begin
            if (p <= 5) begin
                pd = 1;
                v3 = cv(c[4]);
                dd = (d <= dealer_limit(v3));
                p  = (p + v3) % 10;
            end else begin
                dd = (d <= 5);
            end
        end
        if (dd) d = (d + cv(c[5])) % 10;
        seq = ((1 * 8 + 2) * 8 + 3) * 8 + 4;
        if (pd) seq = seq * 8 + 5;
        if (dd) seq = seq * 8 + 6;
        cyc = 5 + (pd ? 2 : 0) + (dd ? 1 : 0);
        pw  = (p >= d);
        dw  = (d >= p);
    endfunction

    function automatic logic [5:0][3:0] mk(input int unsigned p1, d1, p2, d2, p3, d3);
        logic [5:0][3:0] c;
        c[0] = 4'(p1); c[1] = 4'(d1); c[2] = 4'(p2);
        c[3] = 4'(d2); c[4] = 4'(p3); c[5] = 4'(d3);
        return c;
    endfunction

    task automatic run_round(input logic [5:0][3:0] c, input string name);
        int unsigned exp_seq, exp_cyc, seq, edges, multi, lchg;
        int          done_at;
        logic        epw, edw, dpw, ddw;
        logic [5:0]  lv;
        ref_round(c, exp_seq, exp_cyc, epw, edw);
        @(negedge slow_clock);
        resetb = 1'b0;
        cards  = c;
        @(negedge slow_clock);
        resetb  = 1'b1;
        seq     = 0;
        edges   = 0;
        multi   = 0;
        lchg    = 0;
        done_at = -1;
        dpw     = 1'b0;
        ddw     = 1'b0;
        for (int k = 0; k < 20; k++) begin
            #1;
            lv = loads();
            if ($countones(lv) > 1) multi++;
            for (int i = 0; i < 6; i++) if (lv[i]) seq = seq * 8 + i + 1;
            if (done_at >= 0 && (player_win_light !== dpw || dealer_win_light !== ddw)) lchg++;
            if (done_at < 0 && (player_win_light || dealer_win_light)) begin
                done_at = int'(edges);
                dpw     = player_win_light;
                ddw     = dealer_win_light;
            end
            if (done_at >= 0 && int'(edges) >= done_at + 3) break;
            @(negedge slow_clock);
            edges++;
        end
        tests++;
        if (done_at < 0 || done_at !== int'(exp_cyc)) begin
            fails++;
            $display("FAIL %s done_cycle got %0d expected %0d", name, done_at, exp_cyc);
        end
        tests++;
        if (seq !== exp_seq) begin
            fails++;
            $display("FAIL %s load_order got %0o expected %0o", name, seq, exp_seq);
        end
        tests++;
        if (multi !== 0) begin
            fails++;
            $display("FAIL %s multi_load got %0d cycles expected 0", name, multi);
        end
        tests++;
        if (dpw !== epw || ddw !== edw) begin
            fails++;
            $display("FAIL %s lights got p=%b d=%b expected p=%b d=%b", name, dpw, ddw, epw, edw);
        end
        tests++;
        if (lchg !== 0) begin
            fails++;
            $display("FAIL %s done_stable got %0d changes expected 0", name, lchg);
        end
    endtask

    task automatic test_reset();
        @(negedge slow_clock);
        resetb = 1'b0;
        #1;
        tests++;
        if (loads() !== 6'b0) begin
            fails++;
            $display("FAIL reset_loads got %b expected 000000", loads());
        end
        tests++;
        if ({player_win_light, dealer_win_light} !== 2'b00) begin
            fails++;
            $display("FAIL reset_lights got %b expected 00", {player_win_light, dealer_win_light});
        end
        @(negedge slow_clock);
        resetb = 1'b1;
        #1;
        tests++;
        if (loads() !== 6'b000001) begin
            fails++;
            $display("FAIL reset_first_load got %b expected 000001", loads());
        end
    endtask

    task automatic test_directed();
        run_round(mk(3, 1, 5, 2, 9, 9), "natural");
        run_round(mk(2, 1, 2, 2, 8, 9), "player_draws_dealer_stands");
        run_round(mk(3, 2, 3, 3, 9, 4), "player_stands_dealer_draws");
        run_round(mk(2, 1, 2, 3, 12, 5), "face_card_tie");
        run_round(mk(1, 1, 1, 1, 5, 6), "both_draw");
        run_round(mk(13, 10, 11, 12, 12, 13), "all_zero_tie");
    endtask

    task automatic test_reset_mid_round();
        bit seen;
        @(negedge slow_clock);
        resetb = 1'b0;
        cards  = mk(2, 1, 2, 2, 8, 9);
        @(negedge slow_clock);
        resetb = 1'b1;
        seen   = 0;
        for (int k = 0; k < 12 && !seen; k++) begin
            #1;
            if (load_pcard3) seen = 1;
            else @(negedge slow_clock);
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL midreset_reach_p3 got no load_pcard3 expected one within 12 cycles");
        end
        resetb = 1'b0;
        #1;
        tests++;
        if (loads() !== 6'b0 || {player_win_light, dealer_win_light} !== 2'b00) begin
            fails++;
            $display("FAIL midreset_outputs got loads=%b lights=%b expected 000000/00",
                     loads(), {player_win_light, dealer_win_light});
        end
        @(negedge slow_clock);
        resetb = 1'b1;
        #1;
        tests++;
        if (loads() !== 6'b000001) begin
            fails++;
            $display("FAIL midreset_resume got %b expected 000001", loads());
        end
    endtask

    task automatic test_random();
        logic [5:0][3:0] c;
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 6; i++) c[i] = 4'($urandom_range(1, 13));
            run_round(c, $sformatf("random_%0d", n));
        end
    endtask

`ifdef NEW_ROUND_EN
    task automatic test_new_round();
        run_round(mk(3, 1, 5, 2, 9, 9), "pre_new_round");
        tests++;
        if (rounds_played !== 8'd0) begin
            fails++;
            $display("FAIL rounds_before got %0d expected 0", rounds_played);
        end
        new_round = 1'b1;
        @(negedge slow_clock);
        #1;
        new_round = 1'b0;
        tests++;
        if (clear_hand !== 1'b1 || {player_win_light, dealer_win_light} !== 2'b00
            || loads() !== 6'b0) begin
            fails++;
            $display("FAIL clear_state got clear=%b lights=%b loads=%b expected 1/00/000000",
                     clear_hand, {player_win_light, dealer_win_light}, loads());
        end
        tests++;
        if (rounds_played !== 8'd1) begin
            fails++;
            $display("FAIL rounds_after got %0d expected 1", rounds_played);
        end
        @(negedge slow_clock);
        #1;
        tests++;
        if (clear_hand !== 1'b0 || loads() !== 6'b000001) begin
            fails++;
            $display("FAIL after_clear got clear=%b loads=%b expected 0/000001",
                     clear_hand, loads());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_reset_mid_round();
        test_random();
`ifdef NEW_ROUND_EN
        test_new_round();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
